// File: rtl/serial_shift_right_pkg.sv
// Shared types and sizing helpers for the serial right shifter.
// Imported by the interface, the step slice and the top.
package shift_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam int unsigned NBITS_DEFAULT = 32;

    function automatic int unsigned shamt_bits(input int unsigned n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/serial_shift_right_if.sv
// Operand and result handshakes of the serial right shifter, bundled as one interface.
// The slave modport is the shifter side; master is the producer/consumer side.
interface serial_shift_right_if
    import shift_pkg::*;
#(
    parameter int unsigned Nbits     = NBITS_DEFAULT,
    parameter int unsigned ShamtBits = shamt_bits(Nbits)
);

    logic                    in_valid;
    logic                    in_ready;
    logic signed [Nbits-1:0] In;
    logic [ShamtBits-1:0]    shamt;
    logic                    arith;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [Nbits-1:0] Out;
    logic                    busy;

    modport slave (
        input  in_valid,
        input  In,
        input  shamt,
        input  arith,
        input  out_ready,
        output in_ready,
        output out_valid,
        output Out,
        output busy
    );

    modport master (
        output in_valid,
        output In,
        output shamt,
        output arith,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  Out,
        input  busy
    );

endinterface

// File: rtl/serial_shift_right_step.sv
// Combinational one-position right shift; the vacated MSB takes the sign bit when arith is set.
module shift_right_step
    import shift_pkg::*;
#(
    parameter int unsigned Nbits = NBITS_DEFAULT
) (
    input  logic [Nbits-1:0] d,
    input  logic             arith,
    output logic [Nbits-1:0] q
);

    logic w_fill;

    always_comb begin
        w_fill = arith & d[Nbits-1];
        q      = {w_fill, d[Nbits-1:1]};
    end

endmodule

// File: rtl/serial_shift_right.sv
// Multi-cycle right shifter: accepts an operand, shifts one position per clock and
// holds the result until the consumer takes it. No barrel shifter.
module serial_shift_right
    import shift_pkg::*;
#(
    parameter int unsigned Nbits     = NBITS_DEFAULT,
    parameter int unsigned ShamtBits = shamt_bits(Nbits)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_shift_right_if.slave  bus
);

    state_t               state_q, state_d;
    logic [Nbits-1:0]     data_q, data_d;
    logic [ShamtBits-1:0] cnt_q, cnt_d;
    logic                 mode_q, mode_d;
    logic [Nbits-1:0]     w_step;

    shift_right_step #(
        .Nbits (Nbits)
    ) u_step (
        .d     (data_q),
        .arith (mode_q),
        .q     (w_step)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    data_d  = bus.In;
                    cnt_d   = bus.shamt;
                    mode_d  = bus.arith;
                    state_d = (bus.shamt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                // cnt_q is never zero here, so the decrement cannot wrap.
                data_d = w_step;
                cnt_d  = cnt_q - ShamtBits'(1);
                if (cnt_q == ShamtBits'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == DONE);
        bus.busy      = (state_q != IDLE);
        bus.Out       = data_q;
    end

endmodule
